// File: rtl/imem_boot_arbiter_pkg.sv
// Shared types for the instruction-memory boot sequencer.
// Holds FSM state and read-grant encodings.
package imem_boot_arbiter_pkg;

  localparam int DEPTH_DEFAULT = 32;
  localparam int WORD_W        = 32;

  typedef enum logic {
    LOAD,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_FETCH,
    GNT_DBG
  } gnt_e;

endpackage

// File: rtl/imem_rd_arbiter.sv
// Fetch-over-debug read arbiter; a debug read deferred
// MAX_WAIT times in a row is forced through.
module imem_rd_arbiter
  import imem_boot_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic fetch_req,
  input  logic dbg_req,
  output gnt_e gnt
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          starved;
  logic          dbg_win;
  logic          fetch_win;

  always_comb begin
    starved   = (cnt_q == CW'(MAX_WAIT));
    dbg_win   = en && dbg_req && (starved || !fetch_req);
    fetch_win = en && fetch_req && !dbg_win;
    gnt       = GNT_NONE;
    cnt_d     = cnt_q;
    unique case (1'b1)
      dbg_win: begin
        gnt   = GNT_DBG;
        cnt_d = '0;
      end
      fetch_win: begin
        gnt = GNT_FETCH;
        if (dbg_req && !starved)
          cnt_d = cnt_q + 1'b1;
      end
      default: begin
        if (!en)
          cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/imem_boot_arbiter.sv
// Boot loader / fetch / debug sequencer for the instruction memory.
// Option: IMEM_BOOT_ARBITER_CHECKSUM_EN adds load_csum.
module imem_boot_arbiter
  import imem_boot_arbiter_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int AW       = $clog2(DEPTH),
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [31:0]       PC,
  input  logic              fetch_req,
  output logic [WORD_W-1:0] instruction,
  output logic              stall,
  input  logic              dbg_req,
  input  logic [AW-1:0]     dbg_addr,
  output logic              dbg_ack,
  output logic [WORD_W-1:0] dbg_rdata,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              boot_done
`ifdef IMEM_BOOT_ARBITER_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0] load_csum
`endif
);

  state_e            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              ld_ready_q, ld_ready_d;
  logic              stall_q, stall_d;
  logic              done_q, done_d;
  logic              ack_q, ack_d;
  logic              fvld_q, fvld_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] drd_q, drd_d;
  logic              accept;
  logic              load_end;
  gnt_e              gnt;
  logic              unused_pc;

  assign unused_pc = ^{PC[31:AW+2], PC[1:0]};

  imem_rd_arbiter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_arb (
    .clk      (clk),
    .rst_n    (reset),
    .en       (state_q == RUN),
    .fetch_req(fetch_req),
    .dbg_req  (dbg_req),
    .gnt      (gnt)
  );

  assign ld_ready  = ld_ready_q;
  assign stall     = stall_q;
  assign boot_done = done_q;
  assign dbg_ack   = ack_q;

  // Read data arrives the cycle after the grant; hold it otherwise.
  assign instruction = fvld_q ? mem_rdata : instr_q;
  assign dbg_rdata   = ack_q  ? mem_rdata : drd_q;

  always_comb begin
    accept    = (state_q == LOAD) && ld_valid && ld_ready_q;
    load_end  = accept && (ld_last || ptr_q == AW'(DEPTH - 1));
    mem_we    = accept;
    mem_wdata = accept ? ld_data : '0;
    mem_addr  = ptr_q;
    if (state_q == RUN) begin
      unique case (gnt)
        GNT_FETCH: mem_addr = PC[AW+1:2];
        GNT_DBG:   mem_addr = dbg_addr;
        default:   mem_addr = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ld_ready_d = ld_ready_q;
    stall_d    = stall_q;
    done_d     = done_q;
    ack_d      = 1'b0;
    fvld_d     = 1'b0;
    instr_d    = instruction;
    drd_d      = dbg_rdata;
    unique case (state_q)
      LOAD: begin
        ld_ready_d = 1'b1;
        stall_d    = 1'b1;
        if (accept)
          ptr_d = ptr_q + 1'b1;
        if (load_end) begin
          state_d    = RUN;
          ld_ready_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      RUN: begin
        ld_ready_d = 1'b0;
        fvld_d     = (gnt == GNT_FETCH);
        ack_d      = (gnt == GNT_DBG);
        stall_d    = fetch_req && (gnt != GNT_FETCH);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= LOAD;
      ptr_q      <= '0;
      ld_ready_q <= 1'b0;
      stall_q    <= 1'b1;
      done_q     <= 1'b0;
      ack_q      <= 1'b0;
      fvld_q     <= 1'b0;
      instr_q    <= '0;
      drd_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ld_ready_q <= ld_ready_d;
      stall_q    <= stall_d;
      done_q     <= done_d;
      ack_q      <= ack_d;
      fvld_q     <= fvld_d;
      instr_q    <= instr_d;
      drd_q      <= drd_d;
    end
  end

`ifdef IMEM_BOOT_ARBITER_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;

  assign load_csum = csum_q;

  always_comb begin
    csum_d = csum_q;
    if (accept)
      csum_d = csum_q + ld_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end
`endif

endmodule

// File: tb/tb_imem_boot_arbiter.sv
// Randomized bench for imem_boot_arbiter against a
// cycle-level behavioural model with a memory array.
module tb_imem_boot_arbiter;

  localparam int DEPTH    = 32;
  localparam int AW       = 5;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_last = 1'b0;
  logic [31:0]   ld_data = '0;
  logic          ld_ready;
  logic [31:0]   PC = '0;
  logic          fetch_req = 1'b0;
  logic [31:0]   instruction;
  logic          stall;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic          dbg_ack;
  logic [31:0]   dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          boot_done;
`ifdef IMEM_BOOT_ARBITER_CHECKSUM_EN
  logic [31:0]   load_csum;
`endif

  imem_boot_arbiter #(
    .DEPTH(DEPTH), .AW(AW), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last),
    .PC(PC), .fetch_req(fetch_req),
    .instruction(instruction), .stall(stall),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .boot_done(boot_done)
`ifdef IMEM_BOOT_ARBITER_CHECKSUM_EN
    , .load_csum(load_csum)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] lw [DEPTH];

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: what the outputs must be in the current cycle.
  bit          m_run = 0, m_ldr = 0, m_stall = 1, m_done = 0, m_ack = 0;
  int          m_ptr = 0, m_starve = 0;
  logic [31:0] m_instr = 0, m_drd = 0, m_csum = 0;

  function automatic bit dbg_wins(input bit fr, input bit dr, input int st);
    return dr && (!fr || st >= MAX_WAIT);
  endfunction

  function automatic int pc_word(input logic [31:0] pc);
    return int'(pc[31:2]) % DEPTH;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit dw, fw;
    if (!reset) begin
      m_run = 0; m_ptr = 0; m_starve = 0; m_ldr = 0; m_stall = 1;
      m_done = 0; m_ack = 0; m_instr = 0; m_drd = 0; m_csum = 0;
    end else if (!m_run) begin
      m_ack = 0;
      m_stall = 1;
      if (m_ldr && ld_valid) begin
        ref_mem[m_ptr] = ld_data;
        m_csum = m_csum + ld_data;
        if (ld_last || m_ptr == DEPTH - 1) begin
          m_run = 1;
          m_done = 1;
        end
        m_ptr++;
      end
      m_ldr = !m_run;
    end else begin
      dw = dbg_wins(fetch_req, dbg_req, m_starve);
      fw = fetch_req && !dw;
      if (dw) begin
        m_drd = ref_mem[dbg_addr];
        m_starve = 0;
      end else if (fw && dbg_req && m_starve < MAX_WAIT) begin
        m_starve++;
      end
      if (fw) m_instr = ref_mem[pc_word(PC)];
      m_ack = dw;
      m_stall = fetch_req && !fw;
    end
  end

  always @(negedge clk) begin : compare
    bit dw, fw;
    logic [AW-1:0] ea;
    if (cmp_en) begin
      dw = m_run && dbg_wins(fetch_req, dbg_req, m_starve);
      fw = m_run && fetch_req && !dw;
      if (!m_run)  ea = AW'(m_ptr);
      else if (dw) ea = dbg_addr;
      else if (fw) ea = AW'(pc_word(PC));
      else         ea = '0;
      chk("ld_ready", ld_ready, m_ldr);
      chk("stall", stall, m_stall);
      chk("boot_done", boot_done, m_done);
      chk("dbg_ack", dbg_ack, m_ack);
      chk("instruction", instruction, m_instr);
      chk("dbg_rdata", dbg_rdata, m_drd);
      chk("mem_we", mem_we, !m_run && m_ldr && ld_valid);
      chk("mem_addr", mem_addr, ea);
      if (mem_we) chk("mem_wdata", mem_wdata, ld_data);
`ifdef IMEM_BOOT_ARBITER_CHECKSUM_EN
      chk("load_csum", load_csum, m_csum);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fetch_req = 1'b0;
    dbg_req = 1'b0;
    ld_valid = 1'b0;
    ld_last = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic do_load(input int n, input bit use_last, input bit gaps);
    int i = 0;
    int budget = 0;
    bit acc;
    while (i < n && budget < 500) begin
      ld_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld_data = lw[i];
      ld_last = use_last && (i == n - 1);
      acc = ld_valid && ld_ready;
      step();
      if (acc) i++;
      budget++;
    end
    ld_valid = 1'b0;
    ld_last = 1'b0;
    ld_data = '0;
    chk("load_beats", i, n);
  endtask

  initial begin
    int ack_at, acks, n;
    bit ul;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (2) step();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_stall", stall, 1);
    chk("rst_boot_done", boot_done, 0);
    chk("rst_instruction", instruction, 0);
    chk("rst_mem_we", mem_we, 0);
    step();
    reset = 1'b1;

    lw[0] = 32'h20080005;
    lw[1] = 32'h20090003;
    lw[2] = 32'h01095020;
    do_load(3, 1'b1, 1'b0);
    chk("boot_rise", boot_done, 1);
    chk("ready_after_boot", ld_ready, 0);

    fetch_req = 1'b1;
    PC = 32'h8;
    step();
    chk("fetch_pc8", instruction, 32'h01095020);
    chk("fetch_pc8_stall", stall, 0);
    PC = 32'h84;
    step();
    chk("fetch_pc84_wrap", instruction, 32'h20090003);
    fetch_req = 1'b0;
    step();

    do_reset();
    for (int i = 0; i < DEPTH; i++) lw[i] = 32'hA0000000 + i;
    do_load(2, 1'b0, 1'b0);
    chk("midload_done", boot_done, 0);
    chk("midload_ready", ld_ready, 1);
    do_reset();
    for (int i = 0; i < DEPTH; i++) lw[i] = 32'hC0DE0000 + i;
    do_load(32, 1'b0, 1'b1);
    chk("full_done", boot_done, 1);
    chk("full_ready", ld_ready, 0);

    fetch_req = 1'b1;
    PC = 32'h0;
    repeat (2) step();
    dbg_req = 1'b1;
    dbg_addr = 5'd5;
    ack_at = 0;
    acks = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (dbg_ack) begin
        acks++;
        if (ack_at == 0) begin
          ack_at = k;
          chk("dbg_word5", dbg_rdata, 32'hC0DE0005);
          chk("dbg_stall", stall, 1);
        end
        dbg_req = 1'b0;
      end
    end
    chk("dbg_ack_cycle", ack_at, 5);
    chk("dbg_ack_count", acks, 1);
    fetch_req = 1'b0;

`ifdef IMEM_BOOT_ARBITER_CHECKSUM_EN
    do_reset();
    lw[0] = 32'h1;
    lw[1] = 32'h2;
    lw[2] = 32'hFFFFFFFF;
    do_load(3, 1'b1, 1'b0);
    chk("csum_end", load_csum, 32'h2);
    repeat (3) step();
    chk("csum_hold", load_csum, 32'h2);
`endif

    for (int r = 0; r < 6; r++) begin
      do_reset();
      n = $urandom_range(1, DEPTH);
      ul = (n < DEPTH) ? 1'b1 : 1'(($urandom_range(0, 1)));
      for (int i = 0; i < DEPTH; i++) lw[i] = $urandom;
      fetch_req = 1'($urandom_range(0, 1));
      dbg_req = 1'($urandom_range(0, 1));
      dbg_addr = AW'($urandom);
      do_load(n, ul, 1'b1);
      for (int c = 0; c < 250; c++) begin
        fetch_req = ($urandom_range(0, 3) != 0);
        PC = $urandom;
        if (dbg_req && dbg_ack) begin
          dbg_req = ($urandom_range(0, 3) == 0);
          dbg_addr = AW'($urandom);
        end else if (!dbg_req && $urandom_range(0, 2) == 0) begin
          dbg_req = 1'b1;
          dbg_addr = AW'($urandom);
        end
        step();
      end
    end

    fetch_req = 1'b0;
    dbg_req = 1'b0;
    step();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
